// File: rtl/ex_pkg.sv
// Shared constants for the execute-stage issue slot: memory size encodings,
// exception codes, reset PC and functional-unit channel indices.
package ex_pkg;

    typedef enum logic [1:0] {
        MemByte   = 2'd0,
        MemHalf   = 2'd1,
        MemWord   = 2'd2,
        MemDouble = 2'd3
    } mem_size_e;

    localparam logic [5:0]  ALE_ECODE_DEF = 6'h9;
    localparam logic [31:0] RESET_PC_DEF  = 32'h1c00_0000;

    localparam int unsigned FU_MUL = 0;
    localparam int unsigned FU_DIV = 1;

endpackage

// File: rtl/ex_align_check.sv
// Combinational misaligned-access detector; double accesses fall back to word
// alignment when the datapath is narrower than 64 bits.
module ex_align_check
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic       is_mem_i,
    input  logic [1:0] mem_size_i,
    input  logic [2:0] addr_lsb_i,
    output logic       ale_o
);

    localparam logic [2:0] DoubleMask = (XLEN == 64) ? 3'b111 : 3'b011;

    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        unique case (mem_size_e'(mem_size_i))
            MemByte:   misaligned = 1'b0;
            MemHalf:   misaligned = addr_lsb_i[0];
            MemWord:   misaligned = |addr_lsb_i[1:0];
            MemDouble: misaligned = |(addr_lsb_i & DoubleMask);
            default:   misaligned = 1'b0;
        endcase
    end

    assign ale_o = is_mem_i & misaligned;

endmodule

// File: rtl/ex_fu_issue_stage.sv
// Execute-stage slot: issues one request per instruction to a multi-cycle unit,
// flags misaligned accesses and registers the result toward MEM.
module ex_fu_issue_stage
    import ex_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     PAYLOAD_W   = 96,
    parameter int unsigned     NUM_FU      = 2,
    parameter logic [5:0]      ALE_ECODE   = ALE_ECODE_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
    parameter int unsigned     STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_addr,
    input  logic                   in_is_mem,
    input  logic [1:0]             in_mem_size,
    input  logic [NUM_FU-1:0]      in_fu_sel,
    input  logic                   in_exc,
    input  logic [5:0]             in_ecode,
    input  logic [8:0]             in_esubcode,
    input  logic                   in_ertn,

    input  logic                   ex_flush,
    input  logic                   ertn_flush,
    input  logic                   next_flush,
    output logic                   this_flush,

    output logic [NUM_FU-1:0]      fu_req_valid,
    input  logic [NUM_FU-1:0]      fu_req_ready,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_result,
    output logic                   out_exc,
    output logic [5:0]             out_ecode,
    output logic [8:0]             out_esubcode,
    output logic [XLEN-1:0]        out_badv,
    output logic                   out_ertn,
    output logic [NUM_FU-1:0]      out_fu_sel,

    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic ale;
    logic kill;
    logic fu_hs;
    logic ready_go;
    logic adv;
    logic stall_inc;

    logic                   req_done_q, req_done_d;
    logic                   out_valid_q, out_valid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [PAYLOAD_W-1:0] payload_q;
    logic [XLEN-1:0]      pc_q;
    logic [XLEN-1:0]      result_q;
    logic [XLEN-1:0]      badv_q;
    logic                 exc_q;
    logic [5:0]           ecode_q;
    logic [8:0]           esubcode_q;
    logic                 ertn_q;
    logic [NUM_FU-1:0]    fu_sel_q;

    ex_align_check #(
        .XLEN (XLEN)
    ) u_align_check (
        .is_mem_i   (in_is_mem),
        .mem_size_i (in_mem_size),
        .addr_lsb_i (in_addr[2:0]),
        .ale_o      (ale)
    );

    assign kill       = ex_flush | ertn_flush;
    assign this_flush = (in_valid & (in_exc | ale)) | next_flush;

    // req_done_q suppresses re-issue while MEM back-pressures an accepted request.
    assign fu_req_valid = in_fu_sel
                        & {NUM_FU{in_valid & ~req_done_q & ~this_flush & ~kill}};
    assign fu_hs        = |(fu_req_valid & fu_req_ready);

    assign ready_go  = ~in_valid | kill | this_flush | (in_fu_sel == '0) | fu_hs | req_done_q;
    assign in_ready  = ~rst & (~in_valid | (ready_go & out_ready));
    assign adv       = in_valid & ready_go & out_ready;
    assign stall_inc = in_valid & ~kill & ~ready_go;

    always_comb begin
        req_done_d = req_done_q;
        if (adv || kill) begin
            req_done_d = 1'b0;
        end else if (fu_hs && !out_ready) begin
            req_done_d = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (out_ready) begin
            out_valid_d = in_valid & ready_go & ~kill;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            req_done_q  <= req_done_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Upstream exceptions take priority over a locally detected misalignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q  <= '0;
            pc_q       <= RESET_PC;
            result_q   <= '0;
            badv_q     <= '0;
            exc_q      <= 1'b0;
            ecode_q    <= '0;
            esubcode_q <= '0;
            ertn_q     <= 1'b0;
            fu_sel_q   <= '0;
        end else if (adv) begin
            payload_q  <= in_payload;
            pc_q       <= in_pc;
            result_q   <= in_addr;
            badv_q     <= in_addr;
            exc_q      <= in_exc | ale;
            ecode_q    <= in_exc ? in_ecode : (ale ? ALE_ECODE : 6'h0);
            esubcode_q <= in_exc ? in_esubcode : 9'h0;
            ertn_q     <= in_ertn;
            fu_sel_q   <= in_fu_sel;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_payload  = payload_q;
    assign out_pc       = pc_q;
    assign out_result   = result_q;
    assign out_badv     = badv_q;
    assign out_exc      = exc_q;
    assign out_ecode    = ecode_q;
    assign out_esubcode = esubcode_q;
    assign out_ertn     = ertn_q;
    assign out_fu_sel   = fu_sel_q;
    assign stall_cnt    = stall_cnt_q;

endmodule
